fixed_to_float_stream: RTL and testbench
========================================

Name: fixed_to_float_stream

Overview:
- Parametrised successor to the existing fixed-to-float converter.
- Converts a signed two's-complement fixed-point value (integer part plus fraction part) to an IEEE-style binary float.
- Selectable output format and runtime rounding mode.
- Full valid/ready streaming handshake with backpressure, replacing the old clock-enable/done pulse scheme.
- Sits between the fixed-point accumulators and the float result buffers.

Parameters:
- FLOAT_FMT, "float", output format: "half", "float", "double" or "byte_10".
- INT_WID, 40, integer-part width (signed; MSB is the sign bit).
- FRA_WID, 40, fraction-part width (unsigned).
- TAG_WID, 8, width of the sideband tag passed through alongside each sample.
- FLOAT_WID, derived (16/32/64/80), must not be overridden.
- Elaboration error if FRA_WID >= EXP_BIAS-1, or if FLOAT_FMT is not one of the listed strings.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  converter can accept a sample this cycle.
- in_integer  in  INT_WID  signed integer part.
- in_fraction  in  FRA_WID  fraction part.
- in_tag  in  TAG_WID  sideband tag.
- round_mode  in  1  0 = round-to-nearest-even, 1 = truncate toward zero; sampled with each accepted input.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_float  out  FLOAT_WID  {sign, biased exponent, mantissa}.
- out_tag  out  TAG_WID  tag of the sample on out_float.

Behaviour:
- Reset: every pipeline register and all outputs go to 0, including out_valid, out_float and out_tag. in_ready is 1 from the first clock after reset release.
- Pipeline:
  - 5 register stages: leading-sign detect; coarse shift; fine shift; single-bit shift plus low-half round add; high-half carry plus exponent fix-up.
  - Each stage carries a valid bit, the tag and round_mode.
- Handshake:
  - stall = out_valid & ~out_ready. When stall is 1, all stages hold. When stall is 0, all stages advance.
  - in_ready = ~stall (combinational).
  - A transfer occurs on in_valid & in_ready; its result appears exactly 5 cycles later if no stall intervenes. Each stall cycle adds 1.
  - Bubbles propagate as valid=0. Ordering is strictly preserved, and no sample is dropped or duplicated.
  - out_float and out_tag stay stable while out_valid & ~out_ready.
- Conversion:
  - sign = in_integer MSB. Magnitude = |value|, computed without overflow for the most-negative input.
  - The normalised leading 1 sets exponent = EXP_BIAS + (position of leading 1) - FRA_WID.
  - Mantissa = the MANT_WID bits below the leading 1.
  - "byte_10" stores the explicit integer bit at mantissa[63], with 63 fraction bits below it.
- Rounding:
  - RNE: round on guard / sticky bits; exact ties go to even.
  - Truncate: drop all lower bits.
  - A mantissa carry-out increments the exponent and clears the mantissa (for byte_10 it sets the explicit bit).
- Zero input: out_float = all zeros (+0). A negative zero is never produced.
- Overflow: if the exponent reaches all-ones after rounding (possible only in narrow formats):
  - RNE gives ±infinity (exponent all-ones, mantissa 0).
  - Truncate gives ±maximum finite value.
- Reset asserted mid-operation: all in-flight samples are discarded and out_valid drops to 0 asynchronously.
- in_* changing while in_ready=0 has no effect.

Optional Feature:
- Macro FIX2FLT_STATUS_EN.
- When defined, add output out_status [1:0]: bit0 = inexact (discarded bits nonzero), bit1 = overflow.
  - Aligned with out_float, held under stall, reset to 0.
- When undefined, the port and its logic are absent; out_float behaviour is identical either way.

Test Plan:
- float, INT 40/FRA 40: in_integer=1, in_fraction=0 -> out_float=0x3F800000 after 5 cycles. in_integer=-2, in_fraction=0x8000000000 (-1.5) -> 0xBFC00000. All zeros -> 0x00000000.
- Rounding: in_integer=16777219, round_mode=0 -> 0x4B800002 (tie to even). round_mode=1 -> 0x4B800001. in_integer=16777217, RNE -> 0x4B800000.
- Extremes: in_integer=-2^39 -> 0xD3000000. Max positive (all ones except sign, fraction all ones), RNE -> 0x53000000 (carry into exponent).
- Overflow, half format: in_integer=2^20 -> RNE 0x7C00, truncate 0x7BFF. With FIX2FLT_STATUS_EN, out_status=2'b10.
- Backpressure: stream 8 back-to-back samples with tags 0..7 while out_ready=0. in_ready drops once out_valid=1. Releasing out_ready then yields all 8 results in order, tags 0..7, none lost, out_float stable during the stall.
- Reset mid-stream: assert rstn=0 with 3 samples in flight -> out_valid=0 immediately. After release there are no stale outputs; the next input appears 5 cycles after acceptance.

Source files
------------

// File: rtl/fixed_to_float_stream.sv
// fixed_to_float_stream: 5-stage signed fixed-point to binary float, valid/ready.
// Define FIX2FLT_STATUS_EN to add out_status ({overflow, inexact}).
module fixed_to_float_stream #(
  parameter string FLOAT_FMT = "float",
  parameter int    INT_WID   = 40,
  parameter int    FRA_WID   = 40,
  parameter int    TAG_WID   = 8,
  parameter int    FLOAT_WID =
    (FLOAT_FMT == "half")   ? 16 :
    (FLOAT_FMT == "float")  ? 32 :
    (FLOAT_FMT == "double") ? 64 : 80
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INT_WID-1:0]   in_integer,
  input  logic [FRA_WID-1:0]   in_fraction,
  input  logic [TAG_WID-1:0]   in_tag,
  input  logic                 round_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLOAT_WID-1:0] out_float,
`ifdef FIX2FLT_STATUS_EN
  output logic [1:0]           out_status,
`endif
  output logic [TAG_WID-1:0]   out_tag
);

  localparam bit IS_H = (FLOAT_FMT == "half");
  localparam bit IS_F = (FLOAT_FMT == "float");
  localparam bit IS_D = (FLOAT_FMT == "double");
  localparam bit IS_X = (FLOAT_FMT == "byte_10");
  localparam bit FMT_OK = IS_H | IS_F | IS_D | IS_X;
  localparam int EXP_WID = IS_H ? 5 : IS_F ? 8 : IS_D ? 11 : 15;
  localparam int MF = IS_H ? 10 : IS_F ? 23 : IS_D ? 52 : 64;
  localparam int L = IS_X ? 0 : 1;
  localparam int EXP_BIAS = (1 << (EXP_WID - 1)) - 1;
  localparam int EMAX = (1 << EXP_WID) - 1;
  localparam int W = INT_WID + FRA_WID;
  localparam int PW = $clog2(W);
  localparam int EXTW = W - L + MF + 2;
  localparam int LO = MF / 2;
  localparam int HI = MF - LO;

  if (!FMT_OK) begin : g_bad_fmt
    $error("fixed_to_float_stream: unsupported FLOAT_FMT");
  end
  if (FLOAT_WID != 1 + EXP_WID + MF) begin : g_bad_wid
    $error("fixed_to_float_stream: FLOAT_WID must not be overridden");
  end
  if (FRA_WID >= EXP_BIAS - 1) begin : g_bad_fra
    $error("fixed_to_float_stream: FRA_WID too wide for format");
  end

  typedef struct packed {
    logic               vld;
    logic [TAG_WID-1:0] tag;
    logic               rm;
    logic               sgn;
    logic [31:0]        exp;
  } side_t;

  logic          w_stall;
  logic [W-1:0]  w_val;
  logic [W-1:0]  w_mag;
  logic [PW-1:0] w_pos;
  side_t         w_sd0;

  side_t         r1_sd, r2_sd, r3_sd, r4_sd;
  logic [W-1:0]  r1_mag, r2_mag, r3_mag;
  logic [PW-1:0] r1_sh;
  logic [1:0]    r2_sh;
  logic          r3_sh;

  logic [W-1:0]    w_norm;
  logic [EXTW-1:0] w_ext;
  logic [MF-1:0]   w_rnd;
  logic            w_grd, w_stk, w_inc;

  logic [LO:0]     r4_lo;
  logic [HI-1:0]   r4_hi;
  logic            r4_zero;

  logic [HI:0]          w_hi;
  logic                 w_cy;
  logic [MF-1:0]        w_man;
  logic [31:0]          w_exp;
  logic                 w_ovf;
  logic [FLOAT_WID-1:0] w_res;

  logic                 r5_vld;
  logic [FLOAT_WID-1:0] r5_flt;
  logic [TAG_WID-1:0]   r5_tag;

  assign w_stall   = r5_vld & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r5_vld;
  assign out_float = r5_flt;
  assign out_tag   = r5_tag;

  // magnitude of the most-negative value fits as an unsigned W-bit number
  assign w_val = {in_integer, in_fraction};
  assign w_mag = w_val[W-1] ? (~w_val + W'(1)) : w_val;

  always_comb begin
    w_pos = '0;
    for (int i = 0; i < W; i++)
      if (w_mag[i]) w_pos = PW'(i);
  end

  always_comb begin
    w_sd0     = '0;
    w_sd0.vld = in_valid;
    w_sd0.tag = in_tag;
    w_sd0.rm  = round_mode;
    w_sd0.sgn = w_val[W-1];
    w_sd0.exp = 32'(EXP_BIAS - FRA_WID)
              + 32'(w_pos);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_sd  <= '0;
      r1_mag <= '0;
      r1_sh  <= '0;
      r2_sd  <= '0;
      r2_mag <= '0;
      r2_sh  <= '0;
      r3_sd  <= '0;
      r3_mag <= '0;
      r3_sh  <= 1'b0;
    end else if (!w_stall) begin
      r1_sd  <= w_sd0;
      r1_mag <= w_mag;
      r1_sh  <= PW'(W - 1) - w_pos;
      r2_sd  <= r1_sd;
      r2_mag <= r1_mag << {r1_sh[PW-1:2], 2'b00};
      r2_sh  <= r1_sh[1:0];
      r3_sd  <= r2_sd;
      r3_mag <= r2_mag << {r2_sh[1], 1'b0};
      r3_sh  <= r2_sh[0];
    end
  end

  // after normalisation the top bit is clear only for a zero input
  always_comb begin
    w_norm = r3_mag << r3_sh;
    w_ext  = {w_norm[W-1-L:0], {(MF + 2){1'b0}}};
    w_rnd  = w_ext[EXTW-1 -: MF];
    w_grd  = w_ext[EXTW-1-MF];
    w_stk  = |w_ext[EXTW-2-MF:0];
    w_inc  = ~r3_sd.rm & w_grd & (w_stk | w_rnd[0]);
  end

`ifdef FIX2FLT_STATUS_EN
  logic       r4_inx;
  logic [1:0] r5_st;
  assign out_status = r5_st;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r4_sd   <= '0;
      r4_lo   <= '0;
      r4_hi   <= '0;
      r4_zero <= 1'b0;
`ifdef FIX2FLT_STATUS_EN
      r4_inx  <= 1'b0;
`endif
    end else if (!w_stall) begin
      r4_sd   <= r3_sd;
      r4_lo   <= {1'b0, w_rnd[LO-1:0]} + {{LO{1'b0}}, w_inc};
      r4_hi   <= w_rnd[MF-1:LO];
      r4_zero <= ~w_norm[W-1];
`ifdef FIX2FLT_STATUS_EN
      r4_inx  <= w_grd | w_stk;
`endif
    end
  end

  // a carry out of the mantissa bumps the exponent; byte_10 keeps its explicit 1
  always_comb begin
    w_hi  = {1'b0, r4_hi} + {{HI{1'b0}}, r4_lo[LO]};
    w_cy  = w_hi[HI];
    w_man = {w_hi[HI-1:0], r4_lo[LO-1:0]};
    w_man[MF-1] = w_man[MF-1] | (w_cy & IS_X);
    w_exp = r4_sd.exp + 32'(w_cy);
    w_ovf = ~r4_zero & (w_exp >= 32'(EMAX));
    w_res = {r4_sd.sgn, w_exp[EXP_WID-1:0], w_man};
    unique case (1'b1)
      r4_zero:
        w_res = '0;
      w_ovf & ~r4_sd.rm:
        w_res = {r4_sd.sgn, {EXP_WID{1'b1}}, {MF{1'b0}}};
      w_ovf & r4_sd.rm:
        w_res = {r4_sd.sgn, EXP_WID'(EMAX - 1), {MF{1'b1}}};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r5_vld <= 1'b0;
      r5_flt <= '0;
      r5_tag <= '0;
`ifdef FIX2FLT_STATUS_EN
      r5_st  <= '0;
`endif
    end else if (!w_stall) begin
      r5_vld <= r4_sd.vld;
      r5_flt <= w_res;
      r5_tag <= r4_sd.tag;
`ifdef FIX2FLT_STATUS_EN
      r5_st  <= {w_ovf, r4_inx & ~r4_zero};
`endif
    end
  end

endmodule

// File: tb/tb_fixed_to_float_stream.sv
// Scoreboard bench for fixed_to_float_stream: float 40/40 and half 24/8 instances.
// Expected floats are hand-computed constants queued at acceptance time.
module tb_fixed_to_float_stream;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        f_vld, f_irdy, f_rm, f_ovld, f_ordy;
  logic [39:0] f_int, f_fra;
  logic [7:0]  f_tg, f_otag;
  logic [31:0] f_oflt;
  logic [1:0]  f_st;

  logic        h_vld, h_irdy, h_rm, h_ovld, h_ordy;
  logic [23:0] h_int;
  logic [7:0]  h_fra, h_tg, h_otag;
  logic [15:0] h_oflt;
  logic [1:0]  h_st;

  fixed_to_float_stream #(
    .FLOAT_FMT("float"), .INT_WID(40),
    .FRA_WID(40), .TAG_WID(8)
  ) u_f (
    .clk(clk), .rstn(rstn),
    .in_valid(f_vld), .in_ready(f_irdy),
    .in_integer(f_int), .in_fraction(f_fra),
    .in_tag(f_tg), .round_mode(f_rm),
    .out_valid(f_ovld), .out_ready(f_ordy),
    .out_float(f_oflt),
`ifdef FIX2FLT_STATUS_EN
    .out_status(f_st),
`endif
    .out_tag(f_otag)
  );

  fixed_to_float_stream #(
    .FLOAT_FMT("half"), .INT_WID(24),
    .FRA_WID(8), .TAG_WID(8)
  ) u_h (
    .clk(clk), .rstn(rstn),
    .in_valid(h_vld), .in_ready(h_irdy),
    .in_integer(h_int), .in_fraction(h_fra),
    .in_tag(h_tg), .round_mode(h_rm),
    .out_valid(h_ovld), .out_ready(h_ordy),
    .out_float(h_oflt),
`ifdef FIX2FLT_STATUS_EN
    .out_status(h_st),
`endif
    .out_tag(h_otag)
  );

`ifndef FIX2FLT_STATUS_EN
  assign f_st = 2'b00;
  assign h_st = 2'b00;
`endif

  typedef struct {
    logic [63:0] fl;
    logic [7:0]  tg;
    logic [1:0]  st;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t fq[$];
  exp_t hq[$];
  exp_t mit;

  logic [31:0] bp [8] = '{
    32'h3F800000, 32'h40000000,
    32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000,
    32'h40E00000, 32'h41000000
  };

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  // caller is 1 time unit after a rising edge
  task automatic send_f(input logic [39:0] iv,
                        input logic [39:0] fv,
                        input logic rm,
                        input logic [7:0] tg,
                        input logic [31:0] ex,
                        input logic [1:0] st,
                        input bit lat);
    int n;
    exp_t e;
    n = 0;
    f_vld = 1'b1;
    f_int = iv;
    f_fra = fv;
    f_rm  = rm;
    f_tg  = tg;
    @(negedge clk);
    while (!f_irdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!f_irdy) miss("f_send");
    else begin
      e = '{64'(ex), tg, st, cyc, lat};
      fq.push_back(e);
    end
    @(posedge clk);
    #1;
    f_vld = 1'b0;
  endtask

  task automatic send_h(input logic [23:0] iv,
                        input logic [7:0] fv,
                        input logic rm,
                        input logic [7:0] tg,
                        input logic [15:0] ex,
                        input logic [1:0] st);
    int n;
    exp_t e;
    n = 0;
    h_vld = 1'b1;
    h_int = iv;
    h_fra = fv;
    h_rm  = rm;
    h_tg  = tg;
    @(negedge clk);
    while (!h_irdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!h_irdy) miss("h_send");
    else begin
      e = '{64'(ex), tg, st, cyc, 1'b1};
      hq.push_back(e);
    end
    @(posedge clk);
    #1;
    h_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rstn && f_ovld) begin
      if (fq.size() == 0) miss("f_unexpected");
      else if (f_ordy) begin
        mit = fq.pop_front();
        chk("f_float", 64'(f_oflt), mit.fl);
        chk("f_tag", 64'(f_otag), 64'(mit.tg));
`ifdef FIX2FLT_STATUS_EN
        chk("f_status", 64'(f_st), 64'(mit.st));
`endif
        if (mit.lat)
          chk("f_lat", 64'(cyc - mit.cyc), 64'd5);
      end else begin
        chk("f_hold_flt", 64'(f_oflt), fq[0].fl);
        chk("f_hold_tag", 64'(f_otag), 64'(fq[0].tg));
      end
    end
    if (rstn && h_ovld) begin
      if (hq.size() == 0) miss("h_unexpected");
      else if (h_ordy) begin
        mit = hq.pop_front();
        chk("h_float", 64'(h_oflt), mit.fl);
        chk("h_tag", 64'(h_otag), 64'(mit.tg));
`ifdef FIX2FLT_STATUS_EN
        chk("h_status", 64'(h_st), 64'(mit.st));
`endif
        chk("h_lat", 64'(cyc - mit.cyc), 64'd5);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rstn = 1'b0;
    f_vld = 0; f_int = '0; f_fra = '0;
    f_tg = '0; f_rm = 0; f_ordy = 1;
    h_vld = 0; h_int = '0; h_fra = '0;
    h_tg = '0; h_rm = 0; h_ordy = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovld", 64'(f_ovld), 64'd0);
    chk("rst_flt", 64'(f_oflt), 64'd0);
    chk("rst_tag", 64'(f_otag), 64'd0);
    chk("rst_h_ovld", 64'(h_ovld), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_irdy", 64'(f_irdy), 64'd1);
    @(posedge clk);
    #1;

    send_f(40'd1, 40'd0, 0, 8'd1, 32'h3F800000, 2'b00, 1);
    send_f(40'hFF_FFFF_FFFE, 40'h80_0000_0000, 0, 8'd2,
           32'hBFC00000, 2'b00, 1);
    send_f(40'd0, 40'd0, 0, 8'd3, 32'h00000000, 2'b00, 1);
    send_f(40'd0, 40'd0, 1, 8'd4, 32'h00000000, 2'b00, 1);
    send_f(40'd16777219, 40'd0, 0, 8'd5, 32'h4B800002, 2'b01, 1);
    send_f(40'd16777219, 40'd0, 1, 8'd6, 32'h4B800001, 2'b01, 1);
    send_f(40'd16777217, 40'd0, 0, 8'd7, 32'h4B800000, 2'b01, 1);
    send_f(40'h80_0000_0000, 40'd0, 0, 8'd8, 32'hD3000000, 2'b00, 1);
    send_f(40'h7F_FFFF_FFFF, 40'hFF_FFFF_FFFF, 0, 8'd9,
           32'h53000000, 2'b01, 1);
    send_f(40'h7F_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1, 8'd10,
           32'h52FFFFFF, 2'b01, 1);
    send_f(40'd0, 40'd1, 0, 8'd11, 32'h2B800000, 2'b00, 1);
    send_f(40'hFF_FFFF_FFFF, 40'd0, 0, 8'd12, 32'hBF800000, 2'b00, 1);

    w = 0;
    while (fq.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;

    f_ordy = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_f(40'(i + 1), 40'd0, 0, 8'(i), bp[i], 2'b00, 0);
      end
      begin
        w = 0;
        while (!f_ovld && w < 50) begin
          @(negedge clk);
          w++;
        end
        @(negedge clk);
        chk("bp_irdy_low", 64'(f_irdy), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        f_ordy = 1'b1;
      end
    join

    w = 0;
    while (fq.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("bp_drained", 64'(fq.size()), 64'd0);
    @(posedge clk);
    #1;

    f_ordy = 1'b0;
    send_f(40'd2, 40'd0, 0, 8'd20, 32'h40000000, 2'b00, 0);
    send_f(40'd3, 40'd0, 0, 8'd21, 32'h40400000, 2'b00, 0);
    send_f(40'd4, 40'd0, 0, 8'd22, 32'h40800000, 2'b00, 0);
    w = 0;
    while (!f_ovld && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("mid_ovld_pre", 64'(f_ovld), 64'd1);
    rstn = 1'b0;
    #1;
    chk("mid_ovld", 64'(f_ovld), 64'd0);
    chk("mid_flt", 64'(f_oflt), 64'd0);
    chk("mid_tag", 64'(f_otag), 64'd0);
    chk("mid_irdy", 64'(f_irdy), 64'd1);
    fq.delete();
    hq.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    f_ordy = 1'b1;
    send_f(40'd5, 40'd0, 0, 8'd30, 32'h40A00000, 2'b00, 1);

    send_h(24'h100000, 8'd0, 0, 8'd40, 16'h7C00, 2'b10);
    send_h(24'h100000, 8'd0, 1, 8'd41, 16'h7BFF, 2'b10);
    send_h(24'd1, 8'd0, 0, 8'd42, 16'h3C00, 2'b00);
    send_h(24'd65504, 8'd0, 0, 8'd43, 16'h7BFF, 2'b00);
    send_h(24'd65520, 8'd0, 0, 8'd44, 16'h7C00, 2'b11);
    send_h(24'd65520, 8'd0, 1, 8'd45, 16'h7BFF, 2'b01);
    send_h(24'hFFFFFF, 8'h80, 0, 8'd46, 16'hB800, 2'b00);
    send_h(24'd0, 8'd1, 0, 8'd47, 16'h1C00, 2'b00);

    w = 0;
    while ((fq.size() != 0 || hq.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("final_drain", 64'(fq.size() + hq.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
